// File: rtl/cv32e41s_power_ctrl.sv
// cv32e41s_power_ctrl: platform-side responder to the core sleep unit.
// It issues the boot fetch_enable, filters core_sleep into a SLEEP state,
// gates peripheral clocks while asleep and holds interrupts back from the
// core until the peripheral clock has been running for WAKE_DELAY cycles.
// Optional feature: define PWR_CTRL_SLEEP_CNT_EN to build the saturating
// sleep-cycle counter; without it sleep_cnt_o is tied to zero.
module cv32e41s_power_ctrl #(
   parameter int unsigned BOOT_DELAY   = 4,
   parameter int unsigned SLEEP_FILTER = 2,
   parameter int unsigned WAKE_DELAY   = 3,
   parameter int unsigned NUM_IRQ      = 16,
   parameter int unsigned CNT_W        = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               boot_req_i,
   output logic               fetch_enable_o,
   input  logic               core_sleep_i,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_mask_i,
   output logic [NUM_IRQ-1:0] irq_o,
   input  logic               debug_req_i,
   output logic               debug_req_o,
   output logic               periph_clk_en_o,
   output logic               sleep_o,
   input  logic               sleep_cnt_clr_i,
   output logic [CNT_W-1:0]   sleep_cnt_o
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SLEEP = 2'd2,
      ST_WAKE  = 2'd3
   } state_t;

   // A zero delay still needs one edge to leave BOOT/WAKE, so limits floor at 1.
   localparam logic [7:0] BOOT_LIM = (BOOT_DELAY == 0) ? 8'd1 : 8'(BOOT_DELAY);
   localparam logic [7:0] WAKE_LIM = (WAKE_DELAY == 0) ? 8'd1 : 8'(WAKE_DELAY);
   localparam logic [7:0] FILT_LIM = (SLEEP_FILTER == 0) ? 8'd1 : 8'(SLEEP_FILTER);

   state_t     state_r;
   logic       boot_seen_r;
   logic [7:0] boot_cnt_r;
   logic [7:0] filt_cnt_r;
   logic [7:0] wake_cnt_r;
   logic       fetch_enable_r;
   logic       periph_clk_en_r;
   logic       sleep_r;

   logic       wake_ev_s;
   logic       filt_done_s;

   // Wake sources: any unmasked interrupt line or a debug request.
   always_comb begin
      wake_ev_s   = (|(irq_i & irq_mask_i)) | debug_req_i;
      filt_done_s = core_sleep_i & (filt_cnt_r >= (FILT_LIM - 8'd1));
   end

   // Main power FSM with its counters and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r         <= ST_BOOT;
         boot_seen_r     <= 1'b0;
         boot_cnt_r      <= 8'd0;
         filt_cnt_r      <= 8'd0;
         wake_cnt_r      <= 8'd0;
         fetch_enable_r  <= 1'b0;
         periph_clk_en_r <= 1'b1;
         sleep_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               // Only the first sampled request starts the count; later
               // changes of boot_req_i are ignored until the next reset.
               if (boot_seen_r) begin
                  if (boot_cnt_r >= BOOT_LIM) begin
                     state_r        <= ST_RUN;
                     fetch_enable_r <= 1'b1;
                     filt_cnt_r     <= 8'd0;
                  end else begin
                     boot_cnt_r <= boot_cnt_r + 8'd1;
                  end
               end else if (boot_req_i) begin
                  boot_seen_r <= 1'b1;
                  boot_cnt_r  <= 8'd1;
               end else begin
                  boot_cnt_r <= 8'd0;
               end
            end
            ST_RUN: begin
               if (!core_sleep_i) begin
                  filt_cnt_r <= 8'd0;
               end else if (filt_done_s) begin
                  // A wake event racing the filter completion keeps us awake.
                  filt_cnt_r <= 8'd0;
                  if (!wake_ev_s) begin
                     state_r         <= ST_SLEEP;
                     periph_clk_en_r <= 1'b0;
                     sleep_r         <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  filt_cnt_r <= filt_cnt_r + 8'd1;
               end
            end
            ST_SLEEP: begin
               // Core waking on its own beats a pending wake event.
               if (!core_sleep_i) begin
                  state_r         <= ST_RUN;
                  periph_clk_en_r <= 1'b1;
                  sleep_r         <= 1'b0;
                  filt_cnt_r      <= 8'd0;
               end else if (wake_ev_s) begin
                  state_r         <= ST_WAKE;
                  periph_clk_en_r <= 1'b1;
                  sleep_r         <= 1'b0;
                  wake_cnt_r      <= 8'd1;
               end else begin
                  state_r <= ST_SLEEP;
               end
            end
            ST_WAKE: begin
               if (wake_cnt_r >= WAKE_LIM) begin
                  state_r    <= ST_RUN;
                  filt_cnt_r <= 8'd0;
               end else begin
                  wake_cnt_r <= wake_cnt_r + 8'd1;
               end
            end
            default: begin
               state_r         <= ST_BOOT;
               periph_clk_en_r <= 1'b1;
               sleep_r         <= 1'b0;
            end
         endcase
      end
   end

   // Interrupts reach the core only in RUN, unmasked; debug passes straight through.
   always_comb begin
      irq_o       = {NUM_IRQ{1'b0}};
      debug_req_o = debug_req_i;
      if (state_r == ST_RUN) begin
         irq_o = irq_i;
      end else begin
         irq_o = {NUM_IRQ{1'b0}};
      end
   end

   assign fetch_enable_o  = fetch_enable_r;
   assign periph_clk_en_o = periph_clk_en_r;
   assign sleep_o         = sleep_r;

`ifdef PWR_CTRL_SLEEP_CNT_EN
   logic [CNT_W-1:0] sleep_cnt_r;

   // Saturating count of cycles spent in SLEEP; clear has priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sleep_cnt_r <= {CNT_W{1'b0}};
      end else if (sleep_cnt_clr_i) begin
         sleep_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_SLEEP) && (sleep_cnt_r != {CNT_W{1'b1}})) begin
         sleep_cnt_r <= sleep_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         sleep_cnt_r <= sleep_cnt_r;
      end
   end

   assign sleep_cnt_o = sleep_cnt_r;
`else
   logic unused_clr_s;
   assign unused_clr_s = sleep_cnt_clr_i;
   assign sleep_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cv32e41s_power_ctrl.sv
// Bench for cv32e41s_power_ctrl: directed scenarios with literal expectations
// followed by randomized stimulus, all checked against a timeline model.
module tb_cv32e41s_power_ctrl;
   localparam int BOOT_DELAY   = 4;
   localparam int SLEEP_FILTER = 2;
   localparam int WAKE_DELAY   = 3;
   localparam int NI           = 16;
   localparam int BD_EFF       = (BOOT_DELAY < 1) ? 1 : BOOT_DELAY;
   localparam int WD_EFF       = (WAKE_DELAY < 1) ? 1 : WAKE_DELAY;
`ifdef PWR_CTRL_SLEEP_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, boot_req, core_sleep, debug_req, clr;
   logic [NI-1:0] irq, mask;
   logic          fetch, dbg_o, periph, slp;
   logic [NI-1:0] irq_o;
   logic [31:0]   cnt;
   logic          fetch4, dbg_o4, periph4, slp4;
   logic [NI-1:0] irq_o4;
   logic [3:0]    cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cv32e41s_power_ctrl #(.BOOT_DELAY(BOOT_DELAY), .SLEEP_FILTER(SLEEP_FILTER),
      .WAKE_DELAY(WAKE_DELAY), .NUM_IRQ(NI), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .boot_req_i(boot_req), .fetch_enable_o(fetch),
      .core_sleep_i(core_sleep), .irq_i(irq), .irq_mask_i(mask), .irq_o(irq_o),
      .debug_req_i(debug_req), .debug_req_o(dbg_o), .periph_clk_en_o(periph),
      .sleep_o(slp), .sleep_cnt_clr_i(clr), .sleep_cnt_o(cnt));

   cv32e41s_power_ctrl #(.BOOT_DELAY(BOOT_DELAY), .SLEEP_FILTER(SLEEP_FILTER),
      .WAKE_DELAY(WAKE_DELAY), .NUM_IRQ(NI), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .boot_req_i(boot_req), .fetch_enable_o(fetch4),
      .core_sleep_i(core_sleep), .irq_i(irq), .irq_mask_i(mask), .irq_o(irq_o4),
      .debug_req_i(debug_req), .debug_req_o(dbg_o4), .periph_clk_en_o(periph4),
      .sleep_o(slp4), .sleep_cnt_clr_i(clr), .sleep_cnt_o(cnt4));

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // ---------------- timeline model ----------------
   // phase: 0 boot, 1 run, 2 sleep, 3 wake
   int     edge_n = 0;
   bit     m_valid = 1'b0;
   int     m_phase = 0;
   bit     m_fetch = 1'b0;
   bit     m_seen = 1'b0;
   int     m_boot_edge = 0;
   int     m_run_len = 0;
   int     m_wake_edge = 0;
   longint m_cnt = 0;
   int     m_cnt4 = 0;

   always @(posedge clk) begin
      bit wake_ev;
      edge_n++;
      wake_ev = ((irq & mask) != '0) || debug_req;
      if (rst) begin
         m_valid = 1'b1; m_phase = 0; m_fetch = 1'b0; m_seen = 1'b0;
         m_run_len = 0; m_cnt = 0; m_cnt4 = 0;
      end else begin
         if (clr) begin
            m_cnt = 0; m_cnt4 = 0;
         end else if (m_phase == 2) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
         end
         case (m_phase)
            0: begin
               if (m_seen && edge_n == m_boot_edge + BD_EFF) begin
                  m_phase = 1; m_fetch = 1'b1; m_run_len = 0;
               end else if (!m_seen && boot_req) begin
                  m_seen = 1'b1; m_boot_edge = edge_n;
               end
            end
            1: begin
               m_run_len = core_sleep ? m_run_len + 1 : 0;
               if (m_run_len >= SLEEP_FILTER) begin
                  m_run_len = 0;
                  if (!wake_ev) m_phase = 2;
               end
            end
            2: begin
               if (!core_sleep) begin
                  m_phase = 1; m_run_len = 0;
               end else if (wake_ev) begin
                  m_phase = 3; m_wake_edge = edge_n;
               end
            end
            default: begin
               if (edge_n - m_wake_edge >= WD_EFF) begin
                  m_phase = 1; m_run_len = 0;
               end
            end
         endcase
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_fetch", fetch, m_fetch);
         chk("cyc_periph", periph, m_phase != 2);
         chk("cyc_sleep", slp, m_phase == 2);
         chk("cyc_irq", irq_o, (m_phase == 1) ? irq : '0);
         chk("cyc_dbg", dbg_o, debug_req);
         chk("cyc_cnt", cnt, CNT_ON ? m_cnt : 0);
         chk("cyc_cnt4", cnt4, CNT_ON ? m_cnt4 : 0);
         chk("cyc_sleep4", slp4, m_phase == 2);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; boot_req = 1'b0; core_sleep = 1'b0; debug_req = 1'b0;
      clr = 1'b0; irq = '0; mask = '0;
      tick(); tick();                                   // edges 1,2 in reset
      chk("rst_fetch", fetch, 0);
      chk("rst_periph", periph, 1);
      chk("rst_sleep", slp, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_cnt", cnt, 0);
      rst = 1'b0; irq = 16'hFFFF;
      tick(); tick();                                   // edges 3,4
      boot_req = 1'b1;
      tick();                                           // edge 5 samples request
      boot_req = 1'b0;
      tick(); tick(); tick();                           // edges 6,7,8
      chk("boot_fetch_e8", fetch, 0);
      chk("boot_irq_blocked", irq_o, 0);
      tick();                                           // edge 9
      chk("boot_fetch_e9", fetch, 1);
      irq = '0;
      // sleep filter: one cycle is not enough, two are
      core_sleep = 1'b1; tick();
      core_sleep = 1'b0; tick();
      chk("filt_short", slp, 0);
      core_sleep = 1'b1; tick(); tick();
      chk("filt_sleep", slp, 1);
      chk("filt_periph", periph, 0);
      repeat (10) tick();
      chk("cnt_10", cnt, CNT_ON ? 10 : 0);
      irq = 16'h0008; mask = 16'h0000;
      repeat (10) tick();
      chk("masked_stay", slp, 1);
      chk("cnt_20", cnt, CNT_ON ? 20 : 0);
      chk("cnt4_sat", cnt4, CNT_ON ? 15 : 0);
      chk("fetch_sticky", fetch, 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("cnt_clr", cnt, 0);
      mask = 16'h0008; tick();                          // into WAKE
      chk("wake_periph", periph, 1);
      chk("wake_sleep", slp, 0);
      chk("wake_irq1", irq_o, 0);
      tick(); tick();
      chk("wake_irq3", irq_o, 0);
      tick();
      chk("run_irq", irq_o, 16'h0008);
      // race: filter completes together with debug request
      irq = '0; mask = '0; core_sleep = 1'b1; tick();
      debug_req = 1'b1; #1;
      chk("dbg_run", dbg_o, 1);
      tick();
      chk("race_stay", slp, 0);
      debug_req = 1'b0; tick(); tick();
      chk("race_then_sleep", slp, 1);
      debug_req = 1'b1; #1;
      chk("dbg_sleep", dbg_o, 1);
      tick();
      debug_req = 1'b0;
      chk("dbg_wake", periph, 1);
      rst = 1'b1; tick();                               // reset in WAKE
      chk("wrst_fetch", fetch, 0);
      chk("wrst_periph", periph, 1);
      chk("wrst_sleep", slp, 0);
      chk("wrst_irq", irq_o, 0);
      rst = 1'b0; core_sleep = 1'b0;
      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         boot_req   = ($urandom_range(0, 7) == 0);
         core_sleep = ($urandom_range(0, 9) < 8);
         irq        = ($urandom_range(0, 5) == 0) ? NI'($urandom) : '0;
         mask       = NI'($urandom);
         debug_req  = ($urandom_range(0, 40) == 0);
         clr        = ($urandom_range(0, 60) == 0);
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
